hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Producer-side counterpart to the pipeline's forwarding path: it detects the hazards forwarding cannot cover and holds or bubbles the pipeline until a forwardable result exists. It sits beside the ID stage and drives PC/IF_ID write enables, the ID_EX bubble and the IF_ID flush. Stall sequences are tracked by an FSM with a countdown, so a stall, once started, runs deterministically to completion. Saturating performance counters record stall and flush cycles.

Parameters:
CNT_W, 32, width of the stall-cycle and flush-cycle performance counters
LU_ALU_STALL, 1, stall cycles for a load followed by an ALU consumer
LU_BR_STALL, 2, stall cycles for a load followed by a branch consumer in ID

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_is_branch  in  1  ID instruction is a conditional branch resolved in ID
idex_rd  in  5  destination register in EX
idex_rw  in  1  EX instruction writes a register
idex_mr  in  1  EX instruction is a load
exmem_rd  in  5  destination register in MEM
exmem_mr  in  1  MEM instruction is a load
mispredict  in  1  branch resolution in ID disagrees with the prediction
pc_write  out  1  PC register update enable
ifid_write  out  1  IF_ID register update enable
idex_bubble  out  1  load a NOP into ID_EX
ifid_flush  out  1  replace IF_ID contents with a NOP
stall_active  out  1  FSM is in a stall state, or a stall is detected this cycle
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_cycles  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, remaining-count=0, both counters=0, pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, stall_active=0.
- Match rule: match(rd, rs, use) = use && (rd==rs) && (rd!=0). Register x0 never causes a hazard.
- Hazard classes, evaluated only in IDLE:
  - H1 load-use, ALU consumer: idex_mr && idex_rd matches an ID source && !id_is_branch. Stall length LU_ALU_STALL.
  - H2 load-use, branch consumer: idex_mr && match && id_is_branch. Stall length LU_BR_STALL.
  - H3 ALU result needed by a branch: idex_rw && !idex_mr && match && id_is_branch. Stall length 1.
  - H4 load in MEM needed by a branch: exmem_mr && exmem_rd matches an ID source && id_is_branch. Stall length 1.
  - If several classes hit, the longest stall length is used.
- Stall outputs are Mealy: in the detection cycle, pc_write=0, ifid_write=0, idex_bubble=1, stall_active=1. If stall length > 1, go to STALL with remaining = length-1; otherwise stay in IDLE.
- STALL state: pc_write=0, ifid_write=0, idex_bubble=1, stall_active=1. Decrement remaining each cycle; when remaining reaches 1, return to IDLE on that edge. Hazard inputs are ignored in STALL.
- Flush: flush_q = mispredict && !stall_active. A flush asserts ifid_flush=1 for exactly that cycle; pc_write stays 1 so the corrected PC is loaded. A mispredict raised while stalled is ignored, because the branch operands are not yet valid.
- Mispredict and a new hazard in the same IDLE cycle: the stall wins and the flush is suppressed. The branch re-resolves after the stall.
- Counters: stall_cycles increments on every cycle with stall_active=1; flush_cycles increments on every cycle with ifid_flush=1. Both saturate at all-ones with no wrap.
- No outputs are registered apart from the counters; FSM state and remaining-count are registers.
- Reset asserted mid-stall aborts the stall immediately (asynchronous) and returns the block to the reset values above.

Decomposition:
- Shared package: the state encoding (IDLE, STALL), the x0 index constant, and the default stall lengths. The OP_* opcode constants stay where they are.
- One sub-module: sat_counter (width parameter, inc, clk, rst), instantiated twice, for stall_cycles and flush_cycles.

Test Plan:
- H1: idex_mr=1, idex_rd=5, id_rs1=5, id_use_rs1=1, id_is_branch=0 -> exactly 1 cycle of pc_write=0 and idex_bubble=1, then IDLE; stall_cycles=1.
- H2: same as H1 but id_is_branch=1 -> 2 consecutive stall cycles, with inputs changed to non-matching in cycle 2 and the stall still held; stall_cycles=2.
- x0: idex_mr=1, idex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall; pc_write=1 throughout.
- Flush/stall interplay: mispredict=1 with an H3 match (idex_rd=7, id_rs2=7, branch) -> stall, ifid_flush=0. Then mispredict=1 in IDLE with no hazard -> ifid_flush=1 for one cycle; flush_cycles=1.
- Reset mid-stall: assert rst during the second cycle of an H2 stall -> outputs return to reset values immediately, counters=0, state=IDLE.
- Saturation: run with CNT_W=4 through 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared types and constants for the hazard stall unit
package hazard_stall_unit_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } stall_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int DEF_LU_ALU_STALL = 1;
  localparam int DEF_LU_BR_STALL  = 2;

  // x0 is hardwired to zero, so a write to it can never create a dependency
  function automatic logic reg_match(logic [4:0] rd, logic [4:0] rs, logic use_rs);
    return use_rs && (rd == rs) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// rtl/hazard_stall_unit_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch-operand stall and mispredict flush control
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int LU_ALU_STALL = DEF_LU_ALU_STALL,
  parameter int LU_BR_STALL  = DEF_LU_BR_STALL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_branch,
  input  logic [4:0]       idex_rd,
  input  logic             idex_rw,
  input  logic             idex_mr,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_mr,
  input  logic             mispredict,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int MAX_LEN_RAW = (LU_BR_STALL > LU_ALU_STALL) ? LU_BR_STALL : LU_ALU_STALL;
  localparam int MAX_LEN     = (MAX_LEN_RAW > 1) ? MAX_LEN_RAW : 1;
  localparam int REM_W       = $clog2(MAX_LEN + 1);

  stall_state_t     state, state_n;
  logic [REM_W-1:0] rem, rem_n;
  logic [REM_W-1:0] haz_len;
  logic             hit_ex, hit_mem;
  logic             h1, h2, h3, h4, hazard;

  assign hit_ex  = reg_match(idex_rd, id_rs1, id_use_rs1) | reg_match(idex_rd, id_rs2, id_use_rs2);
  assign hit_mem = reg_match(exmem_rd, id_rs1, id_use_rs1) | reg_match(exmem_rd, id_rs2, id_use_rs2);

  assign h1     = idex_mr && hit_ex && !id_is_branch;
  assign h2     = idex_mr && hit_ex && id_is_branch;
  assign h3     = idex_rw && !idex_mr && hit_ex && id_is_branch;
  assign h4     = exmem_mr && hit_mem && id_is_branch;
  assign hazard = h1 | h2 | h3 | h4;

  // Longest stall among all hitting classes
  always_comb begin
    haz_len = (h3 || h4) ? REM_W'(1) : '0;
    if (h1 && (REM_W'(LU_ALU_STALL) > haz_len)) haz_len = REM_W'(LU_ALU_STALL);
    if (h2 && (REM_W'(LU_BR_STALL) > haz_len))  haz_len = REM_W'(LU_BR_STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  // The detection cycle is the first stall cycle, so STALL covers length-1 more
  always_comb begin
    state_n = state;
    rem_n   = rem;
    case (state)
      S_IDLE: begin
        if (hazard && (haz_len > REM_W'(1))) begin
          state_n = S_STALL;
          rem_n   = haz_len - REM_W'(1);
        end
      end
      S_STALL: begin
        if (rem <= REM_W'(1)) begin
          state_n = S_IDLE;
          rem_n   = '0;
        end else begin
          rem_n = rem - REM_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        rem_n   = '0;
      end
    endcase
  end

  // Outputs forced to their idle values while reset is held
  always_comb begin
    stall_active = !rst && ((state == S_STALL) || ((state == S_IDLE) && hazard));
    pc_write     = !stall_active;
    ifid_write   = !stall_active;
    idex_bubble  = stall_active;
    ifid_flush   = !rst && mispredict && !stall_active;
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_active),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_flush),
    .count (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed vector bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1, id_rs2, idex_rd, exmem_rd;
  logic          id_use_rs1, id_use_rs2, id_is_branch;
  logic          idex_rw, idex_mr, exmem_mr, mispredict;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;
  logic [CW-1:0] stall_cycles, flush_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_stall_unit #(.CNT_W(CW), .LU_ALU_STALL(1), .LU_BR_STALL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_branch (id_is_branch),
    .idex_rd      (idex_rd),
    .idex_rw      (idex_rw),
    .idex_mr      (idex_mr),
    .exmem_rd     (exmem_rd),
    .exmem_mr     (exmem_mr),
    .mispredict   (mispredict),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .stall_active (stall_active),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       mis;
    logic       e_stall;
    logic       e_flush;
    logic       e_hold2;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_branch = 1'b0;
    idex_rd = 5'd0; idex_rw = 1'b0; idex_mr = 1'b0;
    exmem_rd = 5'd0; exmem_mr = 1'b0; mispredict = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    id_is_branch = v.br; idex_rd = v.ex_rd; idex_rw = v.ex_rw; idex_mr = v.ex_mr;
    exmem_rd = v.mem_rd; exmem_mr = v.mem_mr; mispredict = v.mis;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_nop();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic st, input logic fl);
    chk({tag, ".pc_write"},     {31'd0, pc_write},     {31'd0, !st});
    chk({tag, ".ifid_write"},   {31'd0, ifid_write},   {31'd0, !st});
    chk({tag, ".idex_bubble"},  {31'd0, idex_bubble},  {31'd0, st});
    chk({tag, ".stall_active"}, {31'd0, stall_active}, {31'd0, st});
    chk({tag, ".ifid_flush"},   {31'd0, ifid_flush},   {31'd0, fl});
  endtask

  initial begin
    //                name          rs1 rs2 u1 u2 br  exrd rw mr  memrd mmr mis  stall flush hold2
    vecs[0]  = '{"h1_alu",        5,  0,  1, 0, 0,  5,   1, 1,  0,    0,  0,   1, 0, 0};
    vecs[1]  = '{"h2_branch",     5,  0,  1, 0, 1,  5,   1, 1,  0,    0,  0,   1, 0, 1};
    vecs[2]  = '{"x0_load",       0,  0,  1, 0, 0,  0,   1, 1,  0,    0,  0,   0, 0, 0};
    vecs[3]  = '{"no_use",        5,  0,  0, 0, 0,  5,   1, 1,  0,    0,  0,   0, 0, 0};
    vecs[4]  = '{"h1_rs2",        1,  9,  1, 1, 0,  9,   1, 1,  0,    0,  0,   1, 0, 0};
    vecs[5]  = '{"h3_alu_br",     1,  7,  1, 1, 1,  7,   1, 0,  0,    0,  0,   1, 0, 0};
    vecs[6]  = '{"alu_fwd_ok",    1,  7,  1, 1, 0,  7,   1, 0,  0,    0,  0,   0, 0, 0};
    vecs[7]  = '{"h4_mem_br",     3,  0,  1, 0, 1,  0,   0, 0,  3,    1,  0,   1, 0, 0};
    vecs[8]  = '{"mem_fwd_ok",    3,  0,  1, 0, 0,  0,   0, 0,  3,    1,  0,   0, 0, 0};
    vecs[9]  = '{"flush_only",    1,  2,  1, 1, 1,  4,   1, 0,  6,    1,  1,   0, 1, 0};
    vecs[10] = '{"mis_plus_h3",   1,  7,  1, 1, 1,  7,   1, 0,  0,    0,  1,   1, 0, 0};
    vecs[11] = '{"h2_h4_longest", 4,  8,  1, 1, 1,  4,   1, 1,  8,    1,  0,   1, 0, 1};

    drive_nop();
    #2;
    chk_outs("reset", 1'b0, 1'b0);
    chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset.flush_cycles", 32'(flush_cycles), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive_vec(vecs[i]);
      #2;
      chk_outs(vecs[i].name, vecs[i].e_stall, vecs[i].e_flush);
      @(negedge clk);
      drive_nop();
      #2;
      chk({vecs[i].name, ".cycle2"}, {31'd0, stall_active}, {31'd0, vecs[i].e_hold2});
      @(negedge clk);
      #2;
      chk({vecs[i].name, ".idle"}, {31'd0, stall_active}, 32'd0);
    end

    // H1: single stall cycle, counted once
    do_reset();
    drive_vec(vecs[0]);
    @(negedge clk);
    drive_nop();
    #2;
    chk("h1.pc_after", {31'd0, pc_write}, 32'd1);
    chk("h1.stall_cycles", 32'(stall_cycles), 32'd1);

    // H2: inputs go non-matching in cycle 2 yet the stall holds; late mispredict ignored
    do_reset();
    drive_vec(vecs[1]);
    @(negedge clk);
    drive_nop();
    mispredict = 1'b1;
    #2;
    chk("h2.c2_pc_write", {31'd0, pc_write}, 32'd0);
    chk("h2.c2_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("h2.c2_no_flush", {31'd0, ifid_flush}, 32'd0);
    @(negedge clk);
    mispredict = 1'b0;
    #2;
    chk("h2.stall_cycles", 32'(stall_cycles), 32'd2);
    chk("h2.flush_cycles", 32'(flush_cycles), 32'd0);
    chk("h2.idle_pc", {31'd0, pc_write}, 32'd1);

    // Mispredict with H3 stalls; the re-resolved mispredict then flushes once
    do_reset();
    drive_vec(vecs[10]);
    #2;
    chk("mis_h3.flush", {31'd0, ifid_flush}, 32'd0);
    @(negedge clk);
    drive_nop();
    mispredict = 1'b1;
    #2;
    chk("mis.flush", {31'd0, ifid_flush}, 32'd1);
    chk("mis.pc_write", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    mispredict = 1'b0;
    #2;
    chk("mis.flush_off", {31'd0, ifid_flush}, 32'd0);
    chk("mis.flush_cycles", 32'(flush_cycles), 32'd1);
    chk("mis.stall_cycles", 32'(stall_cycles), 32'd1);

    // Reset asserted during the second cycle of an H2 stall
    do_reset();
    drive_vec(vecs[1]);
    @(negedge clk);
    #2;
    chk("rst_mid.in_stall", {31'd0, stall_active}, 32'd1);
    rst = 1'b1;
    #1;
    chk_outs("rst_mid", 1'b0, 1'b0);
    chk("rst_mid.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_mid.flush_cycles", 32'(flush_cycles), 32'd0);
    @(negedge clk);
    drive_nop();
    rst = 1'b0;
    #2;
    chk("rst_mid.idle", {31'd0, stall_active}, 32'd0);
    @(negedge clk);
    #2;
    chk("rst_mid.state_idle", {31'd0, stall_active}, 32'd0);
    chk("rst_mid.cnt_after", 32'(stall_cycles), 32'd0);

    // Saturation: 20 back-to-back H1 stall cycles on a 4-bit counter
    do_reset();
    drive_vec(vecs[0]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 14) begin
        #2;
        chk("sat.at15", 32'(stall_cycles), 32'd15);
      end
    end
    drive_nop();
    #2;
    chk("sat.held", 32'(stall_cycles), 32'd15);
    @(negedge clk);
    #2;
    chk("sat.still_held", 32'(stall_cycles), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
